// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns one single-cycle mem-stage request pulse into one
// AXI4-Lite master transaction and returns a one-cycle response pulse.
// Read data and bus-error status come back with the pulse. AxPROT is
// always 3'b000, so there are no prot ports; the slave side sees it as
// tied off. Only one transaction is ever outstanding.
module mem_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // mem-stage side
  input  logic                request_enable,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                response_enable,
  output logic [DATA_W-1:0]   data,
  output logic                access_fault,
  output logic                protocol_error,
  // AXI AR channel
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // AXI R channel
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // AXI AW channel
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // AXI W channel
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI B channel
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     araddr_q;
  logic [ADDR_W-1:0]     awaddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  arvalid_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  rready_q;
  logic                  bready_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  response_q;
  logic [DATA_W-1:0]     data_q;
  logic                  fault_q;
  logic                  perr_q;

  // Handshakes on the two write-request channels, which complete independently.
  logic aw_hs;
  logic w_hs;
  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;

  // Transaction FSM; every output is a register so the AXI side sees clean timing.
  // NOTE: all state here uses non-blocking assignment so every register sees
  // the pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      response_q <= 1'b0;
      data_q     <= '0;
      fault_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      response_q <= 1'b0;
      // A request while a transaction is in flight is dropped but remembered.
      if (request_enable && (state_q != IDLE)) begin
        perr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (request_enable) begin
            araddr_q  <= addr;
            awaddr_q  <= addr;
            wdata_q   <= wdata;
            wstrb_q   <= wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (mode) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid && rready_q) begin
            rready_q   <= 1'b0;
            data_q     <= m_axi_rdata;
            fault_q    <= |m_axi_rresp;
            response_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // Both channels done, counting a handshake landing on this very edge.
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid && bready_q) begin
            bready_q   <= 1'b0;
            data_q     <= '0;
            fault_q    <= |m_axi_bresp;
            response_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axi_araddr    = araddr_q;
  assign m_axi_arvalid   = arvalid_q;
  assign m_axi_rready    = rready_q;
  assign m_axi_awaddr    = awaddr_q;
  assign m_axi_awvalid   = awvalid_q;
  assign m_axi_wdata     = wdata_q;
  assign m_axi_wstrb     = wstrb_q;
  assign m_axi_wvalid    = wvalid_q;
  assign m_axi_bready    = bready_q;
  assign response_enable = response_q;
  assign data            = data_q;
  assign access_fault    = fault_q;
  assign protocol_error  = perr_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge: drives mem-stage requests, plays an AXI4-Lite slave
// with per-transaction wait states and responses, and compares the bridge
// against an expected-response queue.
module tb_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request_enable = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        response_enable;
  logic [31:0] data;
  logic        access_fault;
  logic        protocol_error;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  mem_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .request_enable(request_enable), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb),
    .response_enable(response_enable), .data(data),
    .access_fault(access_fault), .protocol_error(protocol_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  // One transaction as the slave should play it.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          r_dly;
    int          b_dly;
  } txn_t;

  // What the bridge must show for that transaction.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] data;
    bit          fault;
  } exp_t;

  exp_t exp_q[$];
  txn_t cur;
  bit   model_perr = 1'b0;
  bit   junk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave: decides ready/valid for the coming edge, so it knows at drive time
  // whether a handshake will occur.
  int ar_seen, aw_seen, w_seen, r_seen, b_seen;
  bit r_pending, b_pending, aw_ok, w_ok;
  always @(negedge clk) begin
    if (rst) begin
      m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
      m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_bvalid = 0; m_axi_bresp = '0;
      ar_seen = 0; aw_seen = 0; w_seen = 0; r_seen = 0; b_seen = 0;
      r_pending = 0; b_pending = 0; aw_ok = 0; w_ok = 0;
    end else begin
      m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      if (r_pending) begin
        if (r_seen >= cur.r_dly) begin
          m_axi_rvalid = 1; m_axi_rdata = cur.rdata; m_axi_rresp = cur.resp;
          if (m_axi_rready) r_pending = 0;
        end else r_seen++;
      end else if (junk_en && $urandom_range(3) == 0) begin
        m_axi_rvalid = 1; m_axi_rdata = $urandom; m_axi_rresp = 2'($urandom_range(3));
      end
      m_axi_bvalid = 0; m_axi_bresp = '0;
      if (b_pending) begin
        if (b_seen >= cur.b_dly) begin
          m_axi_bvalid = 1; m_axi_bresp = cur.resp;
          if (m_axi_bready) b_pending = 0;
        end else b_seen++;
      end else if (junk_en && $urandom_range(3) == 0) begin
        m_axi_bvalid = 1; m_axi_bresp = 2'($urandom_range(3));
      end
      m_axi_arready = 0;
      if (m_axi_arvalid) begin
        if (ar_seen >= cur.ar_dly) begin
          m_axi_arready = 1; ar_seen = 0; r_pending = 1; r_seen = 0;
        end else ar_seen++;
      end else m_axi_arready = junk_en && ($urandom_range(3) == 0);
      m_axi_awready = 0;
      if (m_axi_awvalid) begin
        if (aw_seen >= cur.aw_dly) begin
          m_axi_awready = 1; aw_seen = 0; aw_ok = 1;
        end else aw_seen++;
      end else m_axi_awready = junk_en && ($urandom_range(3) == 0);
      m_axi_wready = 0;
      if (m_axi_wvalid) begin
        if (w_seen >= cur.w_dly) begin
          m_axi_wready = 1; w_seen = 0; w_ok = 1;
        end else w_seen++;
      end else m_axi_wready = junk_en && ($urandom_range(3) == 0);
      if (aw_ok && w_ok) begin
        b_pending = 1; b_seen = 0; aw_ok = 0; w_ok = 0;
      end
    end
  end

  // Compare process: shortly after every edge, check outputs against the queue.
  logic p_arvalid, p_awvalid, p_wvalid, p_rready, p_bready, p_resp;
  bit   r_hs, b_hs, has;
  exp_t f;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      p_arvalid = 0; p_awvalid = 0; p_wvalid = 0; p_rready = 0; p_bready = 0; p_resp = 0;
    end else begin
      r_hs = p_rready && m_axi_rvalid;
      b_hs = p_bready && m_axi_bvalid;
      check("resp_follows_handshake", 64'(response_enable), 64'(r_hs || b_hs));
      if (response_enable) begin
        check("resp_not_consecutive", 64'(p_resp), 64'(0));
        check("resp_has_txn", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("resp_kind_write", 64'(b_hs), 64'(f.wr));
          check("resp_data", 64'(data), 64'(f.data));
          check("resp_fault", 64'(access_fault), 64'(f.fault));
        end
      end
      has = exp_q.size() > 0;
      if (has) f = exp_q[0];
      if (m_axi_arvalid) begin
        check("arvalid_for_read", 64'(has && !f.wr), 64'(1));
        check("araddr", 64'(m_axi_araddr), 64'(f.addr));
      end
      if (m_axi_awvalid) begin
        check("awvalid_for_write", 64'(has && f.wr), 64'(1));
        check("awaddr", 64'(m_axi_awaddr), 64'(f.addr));
      end
      if (m_axi_wvalid) begin
        check("wvalid_for_write", 64'(has && f.wr), 64'(1));
        check("wdata", 64'(m_axi_wdata), 64'(f.wdata));
        check("wstrb", 64'(m_axi_wstrb), 64'(f.wstrb));
      end
      if (m_axi_rready) check("rready_for_read", 64'(has && !f.wr), 64'(1));
      if (m_axi_bready) check("bready_for_write", 64'(has && f.wr), 64'(1));
      if (p_arvalid && !m_axi_arready) check("arvalid_held", 64'(m_axi_arvalid), 64'(1));
      if (p_awvalid && !m_axi_awready) check("awvalid_held", 64'(m_axi_awvalid), 64'(1));
      if (p_wvalid && !m_axi_wready) check("wvalid_held", 64'(m_axi_wvalid), 64'(1));
      check("protocol_error", 64'(protocol_error), 64'(model_perr));
      p_arvalid = m_axi_arvalid; p_awvalid = m_axi_awvalid; p_wvalid = m_axi_wvalid;
      p_rready = m_axi_rready; p_bready = m_axi_bready; p_resp = response_enable;
    end
  end

  function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [31:0] rd, input logic [1:0] rs,
                              input int ard, input int awd, input int wdl, input int rdl,
                              input int bdl);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.wstrb = ws; t.rdata = rd; t.resp = rs;
    t.ar_dly = ard; t.aw_dly = awd; t.w_dly = wdl; t.r_dly = rdl; t.b_dly = bdl;
    return t;
  endfunction

  function automatic int rdly();
    return ($urandom_range(2) == 0) ? int'($urandom_range(5)) : 0;
  endfunction

  function automatic txn_t rand_txn();
    logic [1:0] rs;
    rs = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
    return mk(1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), $urandom,
              rs, rdly(), rdly(), rdly(), rdly(), rdly());
  endfunction

  // Called at a negedge; returns one negedge later with the pulse removed.
  task automatic issue(input txn_t t);
    exp_t e;
    e.wr = t.wr; e.addr = t.addr; e.wdata = t.wdata; e.wstrb = t.wstrb;
    e.data = t.wr ? 32'h0 : t.rdata;
    e.fault = (t.resp != 2'b00);
    cur = t;
    exp_q.push_back(e);
    request_enable = 1; mode = t.wr; addr = t.addr; wdata = t.wdata; wstrb = t.wstrb;
    @(negedge clk);
    request_enable = 0; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
  endtask

  task automatic busy_pulse();
    request_enable = 1; mode = 1'($urandom_range(1)); addr = $urandom; wdata = $urandom;
    model_perr = 1;
    @(negedge clk);
    request_enable = 0;
  endtask

  // Returns at the first negedge with nothing outstanding (the response cycle).
  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid_ready", 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}), 64'(0));
    rst = 0;
    @(negedge clk);

    // Zero-wait read: araddr in cycle 1, response in cycle 3.
    issue(mk(0, 32'h0000_1004, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0));
    check("rd_arvalid_c1", 64'(m_axi_arvalid), 64'(1));
    check("rd_araddr_c1", 64'(m_axi_araddr), 64'h1004);
    @(negedge clk);
    check("rd_rready_c2", 64'({m_axi_arvalid, m_axi_rready}), 64'(1));
    @(negedge clk);
    check("rd_resp_c3", 64'(response_enable), 64'(1));
    check("rd_data_c3", 64'(data), 64'hDEAD_BEEF);
    check("rd_fault_c3", 64'(access_fault), 64'(0));
    @(negedge clk);
    check("rd_resp_c4", 64'(response_enable), 64'(0));

    // Write with W accepted in cycle 1 and AW held until cycle 4.
    issue(mk(1, 32'h0000_2000, 32'h1122_3344, 4'b0010, 0, 2'b00, 0, 3, 0, 0, 0));
    check("wr_valids_c1", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(3));
    check("wr_wdata_c1", 64'(m_axi_wdata), 64'h1122_3344);
    check("wr_wstrb_c1", 64'(m_axi_wstrb), 64'(2));
    @(negedge clk);
    check("wr_valids_c2", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(2));
    repeat (2) @(negedge clk);
    check("wr_aw_bready_c4", 64'({m_axi_awvalid, m_axi_bready}), 64'(2));
    @(negedge clk);
    check("wr_aw_bready_c5", 64'({m_axi_awvalid, m_axi_bready}), 64'(1));
    @(negedge clk);
    check("wr_resp_c6", 64'({response_enable, access_fault}), 64'(2));
    check("wr_data_c6", 64'(data), 64'(0));

    // SLVERR read, then a clean read issued in the response cycle.
    issue(mk(0, 32'h0000_0040, 0, 0, 32'h1234_5678, 2'b10, 0, 0, 0, 0, 0));
    wait_done("slverr");
    check("slverr_resp", 64'({response_enable, access_fault}), 64'(3));
    issue(mk(0, 32'h0000_0080, 0, 0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0));
    check("b2b_arvalid", 64'(m_axi_arvalid), 64'(1));
    check("b2b_perr", 64'(protocol_error), 64'(0));
    wait_done("b2b");
    check("b2b_fault", 64'({response_enable, access_fault}), 64'(2));
    check("b2b_data", 64'(data), 64'h0BAD_F00D);

    // Request while the read sits in RD_DATA: dropped, sticky error.
    issue(mk(0, 32'h0000_00C0, 0, 0, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 3, 0));
    @(negedge clk);
    check("busy_in_rd_data", 64'(m_axi_rready), 64'(1));
    busy_pulse();
    wait_done("busy");
    check("busy_data", 64'(data), 64'hCAFE_F00D);
    repeat (4) @(negedge clk);
    check("busy_perr_sticky", 64'(protocol_error), 64'(1));

    // Reset clears the sticky error and every output register.
    model_perr = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst_perr", 64'(protocol_error), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    check("rst_araddr", 64'(m_axi_araddr), 64'(0));
    check("rst_awaddr_w", 64'({m_axi_awaddr, m_axi_wstrb}), 64'(0));
    rst = 0;
    @(negedge clk);

    // Stalled slave: arready low 10 cycles, address stable, no response.
    issue(mk(0, 32'h3000_0010, 0, 0, 32'h5A5A_A5A5, 2'b00, 10, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      check("stall_arvalid", 64'({m_axi_arvalid, response_enable}), 64'(2));
      check("stall_araddr", 64'(m_axi_araddr), 64'h3000_0010);
      @(negedge clk);
    end
    wait_done("stall");
    check("stall_data", 64'(data), 64'h5A5A_A5A5);

    // Randomized traffic with spurious slave signals and busy pulses.
    junk_en = 1;
    for (int i = 0; i < 200; i++) begin
      issue(rand_txn());
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3)) @(negedge clk);
        if (exp_q.size() != 0) busy_pulse();
      end
      wait_done("rand");
      repeat ($urandom_range(2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
- Sits directly downstream of the mem stage's bus port.
- Accepts one single-cycle request pulse (read or write, word-aligned address, byte strobes) and turns it into one AXI4-Lite master transaction.
- Returns a one-cycle response pulse with read data, or a completion pulse for writes.
- Flags bus errors (non-OKAY RRESP/BRESP) as an access fault alongside the response.

Parameters:
- ADDR_W, 32, width of the address path.
- DATA_W, 32, width of the data path; WSTRB width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- request_enable  in  1  one-cycle request pulse from mem stage
- mode  in  1  0 = read (MEMREQ_READ), 1 = write (MEMREQ_WRITE)
- addr  in  ADDR_W  word-aligned byte address
- wdata  in  DATA_W  write data, passed through unmodified (no byte swap)
- wstrb  in  DATA_W/8  write byte strobes
- response_enable  out  1  one-cycle completion pulse
- data  out  DATA_W  read data, valid while response_enable=1
- access_fault  out  1  valid with response_enable; 1 if bus returned non-OKAY
- protocol_error  out  1  sticky; set by a request arriving while busy
- m_axi_araddr, m_axi_arvalid (out), m_axi_arready (in): AXI AR channel
- m_axi_rdata, m_axi_rresp[1:0], m_axi_rvalid (in), m_axi_rready (out): AXI R channel
- m_axi_awaddr, m_axi_awvalid (out), m_axi_awready (in): AXI AW channel
- m_axi_wdata, m_axi_wstrb, m_axi_wvalid (out), m_axi_wready (in): AXI W channel
- m_axi_bresp[1:0], m_axi_bvalid (in), m_axi_bready (out): AXI B channel
- All prot signals are tied to 3'b000 (not ports).

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state IDLE.
  - Every valid/ready output 0; response_enable, access_fault, protocol_error 0.
  - data and all m_axi address/data outputs 0.
  - Reset mid-transaction abandons it with no response pulse; the bench must not mix this with live AXI traffic.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE, request_enable=1:
  - Latch addr/wdata/wstrb into the AXI output registers.
  - mode=0: go to RD_ADDR, arvalid=1 next cycle.
  - mode=1: go to WR_REQ, awvalid=1 and wvalid=1 next cycle.
- RD_ADDR:
  - Hold arvalid/araddr stable until arready is sampled high.
  - On that edge: arvalid=0, rready=1, go to RD_DATA.
- RD_DATA:
  - On rvalid&rready: rready=0; next cycle data<=rdata, access_fault<=(rresp!=0), response_enable=1 for exactly one cycle; go to IDLE.
- WR_REQ:
  - AW and W complete independently. Each valid drops on its own handshake; either order or the same cycle is legal.
  - When both are done (tracked by aw_done/w_done flags, cleared on entry): bready=1, go to WR_RESP.
- WR_RESP:
  - On bvalid&bready: bready=0; next cycle response_enable=1, access_fault<=(bresp!=0), data<=0; go to IDLE.
- Latency with a zero-wait-state slave:
  - Read: request cycle 0, AR handshake cycle 1, R handshake cycle 2, response_enable cycle 3.
  - Write: request cycle 0, AW+W cycle 1, B cycle 2, response cycle 3.
- response_enable is never high two consecutive cycles.
- A new request is accepted in the cycle response_enable is high, because the state is already IDLE.
- request_enable while not IDLE: ignored, protocol_error<=1 (sticky until reset); the in-flight transaction is unaffected.
- Only one transaction is outstanding. No read/write reordering.
- Unexpected rvalid/bvalid outside RD_DATA/WR_RESP is ignored (ready is low).
- data holds its last value except on read responses and write responses (where it is cleared to 0).

Test Plan:
- Read, zero-wait slave: request mode=0 addr=0x0000_1004 -> araddr=0x1004 on cycle 1, response_enable on cycle 3, data=0xDEADBEEF (rdata), access_fault=0.
- Write with W before AW: wdata=0x11223344, wstrb=4'b0010; slave asserts wready cycle 1, awready cycle 4 -> awvalid held through cycle 4, bready from cycle 5; bvalid at 5 -> response_enable cycle 6, access_fault=0.
- Slave error: read returns rresp=2'b10 (SLVERR) -> response_enable with access_fault=1; next read with rresp=0 -> access_fault=0.
- Back-to-back: second request issued in the response_enable cycle -> accepted, arvalid next cycle, protocol_error stays 0.
- Request while busy: second pulse during RD_DATA -> ignored, exactly one response, protocol_error=1 until rst.
- Stalled slave: arready low 10 cycles -> arvalid/araddr stable all 10 cycles; no response before the R handshake.
